// File: rtl/fetch_pipelined_pkg.sv
// Shared fetch-path constants: instruction/pc widths, sequential pc step and
// the opcodes the predictor decodes.
package fetch_pipelined_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Queue entry layout: {pc, instr_raw, is_jump_predicted, next_pc}
    localparam int PAYLOAD_W = 3 * INSTR_W + 1;
endpackage

// File: rtl/fetch_pipelined_queue.sv
// Synchronous FIFO with flush for fetched instructions.
// Flush wins over a push in the same cycle. A pop on an empty queue is ignored.
module fetch_queue
    import fetch_pipelined_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PAYLOAD_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Cleared so the head payload reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end
endmodule

// File: rtl/predictor.sv
// Static predictor on a fetched word.
// JAL is always taken. A conditional branch is taken when it points backwards.
module predictor
    import fetch_pipelined_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr_raw,
    input  logic [INSTR_W-1:0] i_current_pc,
    output logic               o_is_jump_predicted,
    output logic [INSTR_W-1:0] o_next_pc
);
    logic [INSTR_W-1:0] w_j_imm;
    logic [INSTR_W-1:0] w_b_imm;

    assign w_j_imm = {{12{i_instr_raw[31]}}, i_instr_raw[19:12], i_instr_raw[20],
                      i_instr_raw[30:21], 1'b0};
    assign w_b_imm = {{20{i_instr_raw[31]}}, i_instr_raw[7], i_instr_raw[30:25],
                      i_instr_raw[11:8], 1'b0};

    always_comb begin
        o_is_jump_predicted = 1'b0;
        o_next_pc           = i_current_pc + INSTR_W'(PC_STEP);
        if (i_instr_raw[6:0] == OPC_JAL) begin
            o_is_jump_predicted = 1'b1;
            o_next_pc           = i_current_pc + w_j_imm;
        end else if (i_instr_raw[6:0] == OPC_BRANCH && i_instr_raw[31]) begin
            o_is_jump_predicted = 1'b1;
            o_next_pc           = i_current_pc + w_b_imm;
        end
    end
endmodule

// File: rtl/fetch_pipelined.sv
// Pipelined instruction fetch: one ROM request per cycle, tag pipe aligned with
// the ROM latency, predictor on returning words, and a flushable output queue.
module fetch_pipelined
    import fetch_pipelined_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          ROM_LATENCY = 2,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_redirect,
    input  logic [31:0]        i_redirect_pc,
    output logic [31:0]        o_rom_addr,
    input  logic [INSTR_W-1:0] i_rom_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [31:0]        o_out_pc,
    output logic [INSTR_W-1:0] o_out_instr_raw,
    output logic               o_out_is_jump_predicted,
    output logic [31:0]        o_out_next_pc
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]                   r_fetch_pc;
    logic [ROM_LATENCY:1]          r_tag_v;
    logic [ROM_LATENCY:1][31:0]    r_tag_pc;

    logic                 w_ret_valid;
    logic [31:0]          w_ret_pc;
    logic                 w_pred_taken;
    logic [31:0]          w_pred_next;
    logic                 w_jump;
    logic                 w_kill_pipe;
    logic [31:0]          w_inflight;
    logic [31:0]          w_total;
    logic                 w_issue;
    logic                 w_push;
    logic [CW-1:0]        w_q_count;
    logic                 w_q_empty;
    logic [PAYLOAD_W-1:0] w_push_data;
    logic [PAYLOAD_W-1:0] w_head;

    assign w_ret_valid = r_tag_v[ROM_LATENCY];
    assign w_ret_pc    = r_tag_pc[ROM_LATENCY];

    predictor u_pred (
        .i_instr_raw        (i_rom_data),
        .i_current_pc       (w_ret_pc),
        .o_is_jump_predicted(w_pred_taken),
        .o_next_pc          (w_pred_next)
    );

    assign w_jump      = w_ret_valid && w_pred_taken;
    assign w_kill_pipe = i_redirect || w_jump;

    always_comb begin
        w_inflight = '0;
        for (int k = 1; k <= ROM_LATENCY; k++) w_inflight = w_inflight + 32'(r_tag_v[k]);
    end

    // Occupancy is taken before this cycle's pop, so a pop only frees a slot
    // for the following cycle and the queue can never be oversubscribed.
    assign w_total = 32'(w_q_count) + w_inflight;
    assign w_issue = (w_total < 32'(QUEUE_DEPTH)) && !w_kill_pipe;
    assign w_push  = w_ret_valid && !i_redirect;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_fetch_pc <= i_redirect_pc;
        end else if (w_jump) begin
            r_fetch_pc <= w_pred_next;
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 32'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tag_v  <= '0;
            r_tag_pc <= '0;
        end else begin
            if (w_kill_pipe) begin
                r_tag_v <= '0;
            end else begin
                r_tag_v[1] <= w_issue;
                for (int k = 2; k <= ROM_LATENCY; k++) r_tag_v[k] <= r_tag_v[k-1];
            end
            r_tag_pc[1] <= r_fetch_pc;
            for (int k = 2; k <= ROM_LATENCY; k++) r_tag_pc[k] <= r_tag_pc[k-1];
        end
    end

    assign w_push_data = {w_ret_pc, i_rom_data, w_pred_taken, w_pred_next};

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH),
        .WIDTH(PAYLOAD_W)
    ) u_queue (
        .clk    (clk),
        .rstn   (rstn),
        .i_flush(i_redirect),
        .i_push (w_push),
        .i_pop  (i_out_ready),
        .i_data (w_push_data),
        .o_data (w_head),
        .o_count(w_q_count),
        .o_empty(w_q_empty)
    );

    assign o_rom_addr  = r_fetch_pc;
    assign o_out_valid = !w_q_empty;
    assign {o_out_pc, o_out_instr_raw, o_out_is_jump_predicted, o_out_next_pc} = w_head;
endmodule

// File: tb/tb_fetch_pipelined.sv
// Directed bench for fetch_pipelined with a 2-cycle ROM whose word at A is A,
// except an optional JAL at 0x8 targeting 0x40.
module tb_fetch_pipelined;
    logic        clk;
    logic        rstn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr_raw;
    logic        out_is_jump_predicted;
    logic [31:0] out_next_pc;

    logic        jal_en;
    logic [31:0] a1, a2;
    int          n_pass;
    int          n_total;

    localparam logic [31:0] JAL_WORD = 32'h0380006F;  // jal x0, +0x38

    fetch_pipelined dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .i_redirect             (redirect),
        .i_redirect_pc          (redirect_pc),
        .o_rom_addr             (rom_addr),
        .i_rom_data             (rom_data),
        .o_out_valid            (out_valid),
        .i_out_ready            (out_ready),
        .o_out_pc               (out_pc),
        .o_out_instr_raw        (out_instr_raw),
        .o_out_is_jump_predicted(out_is_jump_predicted),
        .o_out_next_pc          (out_next_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (jal_en && a == 32'h8) return JAL_WORD;
        return a;
    endfunction

    always @(posedge clk) begin
        a1 <= rom_addr;
        a2 <= a1;
    end
    assign rom_data = rom_word(a2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        clk = 0; rstn = 0; redirect = 0; redirect_pc = 0; out_ready = 1; jal_en = 0;
        n_pass = 0; n_total = 0;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr_raw, 32'h0);
        chk("rst_next", out_next_pc, 32'h0);
        chk("rst_jmp", 32'(out_is_jump_predicted), 32'd0);

        // Streaming: first valid on the third edge after release, then one per cycle
        rstn = 1;
        step(); chk("s_e0_valid", 32'(out_valid), 32'd0);
        step(); chk("s_e1_valid", 32'(out_valid), 32'd0);
        step(); chk_head("s_first", 32'h0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk_head("s_stream", 32'(4 * i));
            chk("s_instr", out_instr_raw, 32'(4 * i));
            chk("s_next", out_next_pc, 32'(4 * i + 4));
            chk("s_jmp", 32'(out_is_jump_predicted), 32'd0);
        end

        // Backpressure: four words fetched, address parks at 0x10, head stable
        out_ready = 0;
        do_reset();
        repeat (10) step();
        chk("bp_addr", rom_addr, 32'h10);
        chk_head("bp_head", 32'h0);
        step();
        chk("bp_addr_hold", rom_addr, 32'h10);
        chk_head("bp_head_hold", 32'h0);
        out_ready = 1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk_head("bp_drain", 32'(4 * i));
        end

        // External redirect with words in flight
        redirect = 1; redirect_pc = 32'h100;
        step();
        redirect = 0;
        chk("rd_valid0", 32'(out_valid), 32'd0);
        chk("rd_addr", rom_addr, 32'h100);
        step(); chk("rd_valid1", 32'(out_valid), 32'd0);
        step(); chk("rd_valid2", 32'(out_valid), 32'd0);
        step(); chk_head("rd_first", 32'h100);
        step(); chk_head("rd_second", 32'h104);
        step(); chk_head("rd_third", 32'h108);

        // Predicted JAL at 0x8 to 0x40
        jal_en = 1;
        do_reset();
        step(); step(); step(); chk_head("j_0", 32'h0);
        step(); chk_head("j_4", 32'h4);
        step(); chk_head("j_8", 32'h8);
        chk("j_instr", out_instr_raw, JAL_WORD);
        chk("j_taken", 32'(out_is_jump_predicted), 32'd1);
        chk("j_next", out_next_pc, 32'h40);
        chk("j_addr", rom_addr, 32'h40);
        step(); chk("j_gap0", 32'(out_valid), 32'd0);
        step(); chk("j_gap1", 32'(out_valid), 32'd0);
        step(); chk_head("j_target", 32'h40);
        step(); chk_head("j_target4", 32'h44);

        // Redirect in the cycle the JAL word returns
        do_reset();
        step(); step(); step(); chk_head("jr_0", 32'h0);
        step(); chk_head("jr_4", 32'h4);
        redirect = 1; redirect_pc = 32'h200;
        step();
        redirect = 0;
        chk("jr_valid0", 32'(out_valid), 32'd0);
        chk("jr_addr", rom_addr, 32'h200);
        step(); chk("jr_valid1", 32'(out_valid), 32'd0);
        step(); chk("jr_valid2", 32'(out_valid), 32'd0);
        step(); chk_head("jr_first", 32'h200);
        step(); chk_head("jr_second", 32'h204);

        // One-cycle reset with a full queue
        jal_en = 0;
        out_ready = 0;
        do_reset();
        repeat (8) step();
        chk_head("mr_full", 32'h0);
        chk("mr_full_addr", rom_addr, 32'h10);
        rstn = 0;
        step();
        rstn = 1;
        out_ready = 1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_addr", rom_addr, 32'h0);
        chk("mr_pc", out_pc, 32'h0);
        step(); chk("mr_e0_valid", 32'(out_valid), 32'd0);
        step(); chk("mr_e1_valid", 32'(out_valid), 32'd0);
        step(); chk_head("mr_first", 32'h0);
        step(); chk_head("mr_second", 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
